// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the convolution sequencers.
//   - conv_state_e : FSM state encoding (IDLE, CLEAR, ACCUM, DRAIN, OUTPUT, DONE)
//   - DEF_*        : default geometry constants
//   - out_dim()    : output extent for stride 1, valid padding (OUT_W / OUT_H)
//   - taps()       : number of window taps (TAPS = K*K)
//   - cnt_w()      : counter width able to hold 0..n-1 (at least 1 bit)
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_OUTPUT = 3'd4,
        ST_DONE   = 3'd5
    } conv_state_e;

    localparam int DEF_IMG_W   = 8;
    localparam int DEF_IMG_H   = 8;
    localparam int DEF_K       = 3;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_WADDR_W = 4;
    localparam int DEF_COORD_W = 4;

    function automatic int out_dim(input int img, input int k);
        return img - k + 1;
    endfunction

    function automatic int taps(input int k);
        return k * k;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/win_counter.sv
// win_counter: nested kr/kc tap counter over a KxK window, row-major order.
//   clk, rst  : clock, synchronous active-high reset
//   clr_i     : force the counter back to tap (0,0)
//   adv_i     : step to the next tap; after (K-1,K-1) it wraps to (0,0)
//   kr_o/kc_o : current tap coordinates
//   last_o    : current tap is (K-1,K-1)
module win_counter
    import conv_pkg::*;
#(
    parameter int K  = DEF_K,
    parameter int KW = cnt_w(K)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          adv_i,
    output logic [KW-1:0] kr_o,
    output logic [KW-1:0] kc_o,
    output logic          last_o
);

    logic [KW-1:0] kr_q;
    logic [KW-1:0] kc_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            kr_q <= '0;
            kc_q <= '0;
        end else if (adv_i) begin
            if (kc_q == KW'(K - 1)) begin
                kc_q <= '0;
                kr_q <= (kr_q == KW'(K - 1)) ? '0 : kr_q + 1'b1;
            end else begin
                kc_q <= kc_q + 1'b1;
            end
        end
    end

    assign kr_o   = kr_q;
    assign kc_o   = kc_q;
    assign last_o = (kr_q == KW'(K - 1)) && (kc_q == KW'(K - 1));

endmodule

// File: rtl/conv_mac_sequencer.sv
// conv_mac_sequencer: sequences one shared MAC over every KxK window
// (stride 1, valid padding) of an IMG_H x IMG_W feature map.
//   clk, rst         : clock, synchronous active-high reset
//   start            : one-cycle pulse, begins a frame when idle
//   busy / done      : frame in progress / one-cycle completion pulse
//   ifm_addr         : feature-map read address (1-cycle read latency)
//   wgt_addr         : weight read address (1-cycle read latency)
//   mac_clr/en/last  : accumulator clear, accumulate, final accumulate
//   out_valid/ready  : result handshake; a transfer happens in a cycle
//                      where both are high, out_valid is held until then
//   out_row/out_col  : output position of the current result
//   stall_cnt        : (PERF_CNT_EN only) saturating count of cycles with
//                      out_valid=1 and out_ready=0, cleared on accepted start
//   dbg_state        : current FSM state
// Optional feature macro: PERF_CNT_EN.
module conv_mac_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H,
    parameter int K       = DEF_K,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int WADDR_W = DEF_WADDR_W,
    parameter int COORD_W = DEF_COORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  ifm_addr,
    output logic [WADDR_W-1:0] wgt_addr,
    output logic               mac_clr,
    output logic               mac_en,
    output logic               mac_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_row,
    output logic [COORD_W-1:0] out_col,
`ifdef PERF_CNT_EN
    output logic [15:0]        stall_cnt,
`endif
    output conv_state_e        dbg_state
);

    localparam int OUT_W = out_dim(IMG_W, K);
    localparam int OUT_H = out_dim(IMG_H, K);
    localparam int KW    = cnt_w(K);

    conv_state_e        state_q;
    logic [COORD_W-1:0] row_q, col_q;
    logic               busy_q, done_q, out_valid_q;
    logic               mac_clr_q, mac_en_q, mac_last_q;
    logic [ADDR_W-1:0]  ifm_addr_q;
    logic [WADDR_W-1:0] wgt_addr_q;
    logic               issued_last_q;   // the tap on the address bus is the window's last

    logic [KW-1:0]      kr, kc;
    logic               win_last;
    logic               win_adv;
    logic [ADDR_W-1:0]  ifm_addr_d;
    logic [WADDR_W-1:0] wgt_addr_d;

    // The tap counter always holds the tap to be issued at the next edge:
    // it sits at (0,0) in CLEAR and wraps back there after the last tap.
    assign win_adv = (state_q == ST_CLEAR) || ((state_q == ST_ACCUM) && !issued_last_q);

    win_counter #(.K(K), .KW(KW)) u_win (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == ST_IDLE),
        .adv_i  (win_adv),
        .kr_o   (kr),
        .kc_o   (kc),
        .last_o (win_last)
    );

    assign ifm_addr_d = ADDR_W'((32'(row_q) + 32'(kr)) * 32'(IMG_W) + 32'(col_q) + 32'(kc));
    assign wgt_addr_d = WADDR_W'(32'(kr) * 32'(K) + 32'(kc));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            row_q         <= '0;
            col_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            mac_clr_q     <= 1'b0;
            mac_en_q      <= 1'b0;
            mac_last_q    <= 1'b0;
            ifm_addr_q    <= '0;
            wgt_addr_q    <= '0;
            issued_last_q <= 1'b0;
        end else begin
            mac_clr_q  <= 1'b0;
            mac_en_q   <= 1'b0;
            mac_last_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_CLEAR;
                        busy_q    <= 1'b1;
                        mac_clr_q <= 1'b1;
                        row_q     <= '0;
                        col_q     <= '0;
                    end
                end
                ST_CLEAR: begin
                    ifm_addr_q    <= ifm_addr_d;
                    wgt_addr_q    <= wgt_addr_d;
                    issued_last_q <= win_last;
                    state_q       <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    // Data for the address shown now arrives next cycle.
                    mac_en_q <= 1'b1;
                    if (issued_last_q) begin
                        mac_last_q <= 1'b1;
                        state_q    <= ST_DRAIN;
                    end else begin
                        ifm_addr_q    <= ifm_addr_d;
                        wgt_addr_q    <= wgt_addr_d;
                        issued_last_q <= win_last;
                    end
                end
                ST_DRAIN: begin
                    out_valid_q <= 1'b1;
                    state_q     <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (col_q == COORD_W'(OUT_W - 1)) begin
                            col_q <= '0;
                            if (row_q == COORD_W'(OUT_H - 1)) begin
                                row_q   <= '0;
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                row_q     <= row_q + 1'b1;
                                state_q   <= ST_CLEAR;
                                mac_clr_q <= 1'b1;
                            end
                        end else begin
                            col_q     <= col_q + 1'b1;
                            state_q   <= ST_CLEAR;
                            mac_clr_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            stall_cnt_q <= '0;
        end else if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign ifm_addr  = ifm_addr_q;
    assign wgt_addr  = wgt_addr_q;
    assign mac_clr   = mac_clr_q;
    assign mac_en    = mac_en_q;
    assign mac_last  = mac_last_q;
    assign out_valid = out_valid_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign dbg_state = state_q;

endmodule
